multi_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one iterative shift-add multiplier among NREQ requesters.

---
 rtl/multi_rr_sched.sv | 136 +++++++++++++
 tb/tb_multi_rr_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rr_sched.sv
// Round-robin front end for one shared iterative multiplier: grants one requester,
// issues its operands, accumulates the partial products and returns the tagged result.
module multi_rr_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TMO_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_vld_i,
  output logic [NREQ-1:0]   req_rdy_o,
  input  logic [NREQ*8-1:0] req_in0_i,
  input  logic [NREQ*8-1:0] req_in1_i,
  output logic              mul_vld_o,
  output logic [7:0]        mul_in0_o,
  output logic [7:0]        mul_in1_o,
  input  logic              mul_busy_i,
  input  logic              mul_out_vld_i,
  input  logic [15:0]       mul_out_data_i,
  output logic              rsp_vld_o,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [15:0]       rsp_data_o,
  output logic              rsp_err_o,
  input  logic              rsp_rdy_i
);

  localparam int WDW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     in0_q, in0_d;
  logic [7:0]     in1_q, in1_d;
  logic [15:0]    acc_q, acc_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;

  logic           any_vld;
  logic [IDW-1:0] win;
  int             idx;

  // Rotating priority search starting at rr_ptr_q.
  always_comb begin
    any_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!any_vld && req_vld_i[idx]) begin
        any_vld = 1'b1;
        win     = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      acc_q    <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      acc_q    <= acc_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    in0_d     = in0_q;
    in1_d     = in1_q;
    acc_d     = acc_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    req_rdy_o = '0;
    mul_vld_o = 1'b0;
    rsp_vld_o = 1'b0;
    case (state_q)
      IDLE: begin
        // A job aborted by the watchdog may leave the multiplier busy; hold off the grant.
        if (any_vld && !mul_busy_i) begin
          req_rdy_o[win] = 1'b1;
          id_d     = win;
          in0_d    = req_in0_i[8*int'(win) +: 8];
          in1_d    = req_in1_i[8*int'(win) +: 8];
          acc_d    = '0;
          wdog_d   = '0;
          err_d    = 1'b0;
          rr_ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mul_vld_o = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        if (mul_out_vld_i) acc_d = acc_q + mul_out_data_i;
        if (!mul_busy_i) begin
          state_d = RESP;
        end else if (wdog_q == WDW'(TMO_CYC-1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      RESP: begin
        rsp_vld_o = 1'b1;
        if (rsp_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_in0_o  = in0_q;
  assign mul_in1_o  = in1_q;
  assign rsp_id_o   = (state_q == RESP) ? id_q : '0;
  assign rsp_err_o  = (state_q == RESP) && err_q;
  assign rsp_data_o = (state_q == RESP && !err_q) ? acc_q : 16'h0000;

endmodule

// File: tb/tb_multi_rr_sched.sv
// Directed bench for multi_rr_sched; the multiplier side is driven step by step
// with hand-chosen partial products so every expected result is known up front.
module tb_multi_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_vld;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*8-1:0] req_in0;
  logic [NREQ*8-1:0] req_in1;
  logic              mul_vld;
  logic [7:0]        mul_in0;
  logic [7:0]        mul_in1;
  logic              mul_busy;
  logic              mul_out_vld;
  logic [15:0]       mul_out_data;
  logic              rsp_vld;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_data;
  logic              rsp_err;
  logic              rsp_rdy;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  multi_rr_sched #(.NREQ(NREQ), .IDW(IDW), .TMO_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy),
    .req_in0_i(req_in0), .req_in1_i(req_in1),
    .mul_vld_o(mul_vld), .mul_in0_o(mul_in0), .mul_in1_o(mul_in1),
    .mul_busy_i(mul_busy), .mul_out_vld_i(mul_out_vld), .mul_out_data_i(mul_out_data),
    .rsp_vld_o(rsp_vld), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .rsp_rdy_i(rsp_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Two RUN cycles: busy with pp a, then done with pp b.
  task automatic mul_two_pp(input logic [15:0] a, input logic [15:0] b);
    mul_busy = 1'b1; mul_out_vld = 1'b1; mul_out_data = a;
    tick();
    mul_busy = 1'b0; mul_out_vld = 1'b1; mul_out_data = b;
    tick();
    mul_out_vld = 1'b0; mul_out_data = '0;
  endtask

  task automatic chk_resp(input string tag, input logic [1:0] id, input logic [15:0] data, input logic err);
    settle();
    chk({tag, "_vld"}, 32'(rsp_vld), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_data"}, 32'(rsp_data), 32'(data));
    chk({tag, "_err"}, 32'(rsp_err), 32'(err));
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_in0 = '0; req_in1 = '0;
    mul_busy = 1'b0; mul_out_vld = 1'b0; mul_out_data = '0; rsp_rdy = 1'b0;
    tick(); tick();
    settle();
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_mul_vld", 32'(mul_vld), 32'd0);
    chk("rst_mul_in0", 32'(mul_in0), 32'd0);
    chk("rst_mul_in1", 32'(mul_in1), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    // T1 single job on requester 0: 3*5 via pp 3 + 12
    req_vld = 4'b0001; req_in0[7:0] = 8'd3; req_in1[7:0] = 8'd5;
    settle();
    chk("t1_req_rdy", 32'(req_rdy), 32'b0001);
    tick();
    req_vld = '0;
    settle();
    chk("t1_mul_vld", 32'(mul_vld), 32'd1);
    chk("t1_mul_in0", 32'(mul_in0), 32'd3);
    chk("t1_mul_in1", 32'(mul_in1), 32'd5);
    chk("t1_issue_rdy", 32'(req_rdy), 32'd0);
    tick();
    settle();
    chk("t1_mul_vld_once", 32'(mul_vld), 32'd0);
    mul_two_pp(16'd3, 16'd12);
    chk_resp("t1_rsp", 2'd0, 16'd15, 1'b0);
    rsp_rdy = 1'b1;
    tick();
    settle();
    chk("t1_back_idle", 32'(rsp_vld), 32'd0);

    // T6 reset in RUN: job on requester 2 dropped, rr_ptr back to 0
    req_vld = 4'b0100; req_in0[23:16] = 8'd9; req_in1[23:16] = 8'd9;
    tick();
    req_vld = '0;
    tick();
    mul_busy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mul_busy = 1'b0;
    settle();
    chk("t6_mul_vld", 32'(mul_vld), 32'd0);
    chk("t6_mul_in0", 32'(mul_in0), 32'd0);
    chk("t6_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("t6_rsp_id", 32'(rsp_id), 32'd0);
    tick(); tick(); tick();
    settle();
    chk("t6_no_rsp", 32'(rsp_vld), 32'd0);

    // T2 round robin with all requesters held: grants 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) begin
      req_in0[8*i +: 8] = 8'(i + 1);
      req_in1[8*i +: 8] = 8'd2;
    end
    req_vld = 4'b1111; rsp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t2_req_rdy", 32'(req_rdy), 32'(1 << (k % 4)));
      tick();
      settle();
      chk("t2_mul_vld", 32'(mul_vld), 32'd1);
      chk("t2_mul_in0", 32'(mul_in0), 32'((k % 4) + 1));
      tick();
      mul_two_pp(16'(16 * (k % 4)), 16'd1);
      chk_resp("t2_rsp", 2'(k % 4), 16'(16 * (k % 4) + 1), 1'b0);
      chk("t2_resp_rdy", 32'(req_rdy), 32'd0);
      tick();
    end

    // T3 backpressure on requester 1 with other requests waiting
    req_vld = 4'b0010; req_in0[15:8] = 8'd7; rsp_rdy = 1'b0;
    tick();
    req_vld = '0;
    tick();
    mul_two_pp(16'h0100, 16'h0023);
    req_vld = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      mul_out_vld = 1'b1; mul_out_data = 16'h0f0f;
      chk_resp("t3_hold", 2'd1, 16'h0123, 1'b0);
      chk("t3_req_rdy", 32'(req_rdy), 32'd0);
      chk("t3_mul_vld", 32'(mul_vld), 32'd0);
      tick();
    end
    mul_out_vld = 1'b0; mul_out_data = '0;
    rsp_rdy = 1'b1;
    tick();
    settle();
    chk("t3_next_grant", 32'(req_rdy), 32'b0100);

    // T4 zero operand on requester 2: busy one cycle, no partial products
    req_vld = 4'b0100; req_in1[23:16] = 8'd0;
    tick();
    req_vld = '0;
    settle();
    chk("t4_mul_in1", 32'(mul_in1), 32'd0);
    tick();
    mul_busy = 1'b1;
    tick();
    mul_busy = 1'b0;
    tick();
    chk_resp("t4_rsp", 2'd2, 16'd0, 1'b0);
    tick();

    // T5 watchdog on requester 3: busy stuck, abort after TMO RUN cycles
    req_vld = 4'b1000;
    tick();
    req_vld = '0;
    mul_busy = 1'b1; mul_out_vld = 1'b1; mul_out_data = 16'd5;
    tick();
    for (int c = 0; c < TMO - 1; c++) begin
      settle();
      chk("t5_run_no_rsp", 32'(rsp_vld), 32'd0);
      tick();
    end
    settle();
    chk("t5_last_run", 32'(rsp_vld), 32'd0);
    tick();
    mul_out_vld = 1'b0; mul_out_data = '0;
    chk_resp("t5_abort", 2'd3, 16'd0, 1'b1);
    tick();
    req_vld = 4'b0001; req_in0[7:0] = 8'd4;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t5_wait_rdy", 32'(req_rdy), 32'd0);
      chk("t5_wait_issue", 32'(mul_vld), 32'd0);
      tick();
    end
    mul_busy = 1'b0;
    settle();
    chk("t5_grant_after_idle", 32'(req_rdy), 32'b0001);
    tick();
    req_vld = '0;
    settle();
    chk("t5_issue", 32'(mul_vld), 32'd1);
    tick();
    mul_two_pp(16'd0, 16'd9);
    chk_resp("t5_recover", 2'd0, 16'd9, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
